bar_peak_shadow: RTL

Parametrised peak-hold/fade engine for the spectrum bar display. It is the generalised successor of the single-width shadow block. Per column it tracks a peak height, a hold counter and a fading colour, all in one inferred single-port RAM. Each frame the column scanner streams one Bar sample per column; the block returns the post-update peak (Top) and fade level (Color) for the renderer.

---
 rtl/bar_peak_shadow.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bar_peak_shadow.sv
// ---------------------------------------------------------------------------
// bar_peak_shadow
//
// Peak-hold / fade engine for the spectrum bar display. Every column keeps a
// peak height, a hold counter and a fading colour in one inferred RAM. The
// column scanner streams one Bar sample per column per frame. Two clocks
// later the block returns the updated peak (Top) and the fade level (Color)
// for that column, and writes the new state back to the RAM.
//
// Optional feature (compile-time macro):
//   BAR_PEAK_SHADOW_GRAVITY_EN - adds a 3-bit per-column fall velocity. Each
//   falling update drops the peak by FALL_STEP + velocity and then increments
//   the velocity, which saturates at 7. A new peak capture clears it. When
//   the macro is not defined the fall step is always FALL_STEP and the RAM
//   word has no velocity field.
//
// Parameters:
//   COLUMNS       columns per frame (RAM depth)
//   ADDR_W        column address width, 2**ADDR_W >= COLUMNS
//   HEIGHT_W      bar / peak height width
//   COLOR_W       output colour width
//   FP            fractional bits of the stored colour
//   COLOR_PRESET  integer colour loaded when a new peak is captured
//   HOLD_FRAMES   frames a captured peak is held before it starts to fall
//   FALL_STEP     base peak fall per frame once the hold has expired
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous active-high reset (RAM contents untouched)
//   Clear     in   synchronous pulse, re-runs RAM initialisation
//   NewFrame  in   pulse, the next accepted Start uses column 0
//   Start     in   one column sample valid this cycle
//   Bar       in   current bar height for this column
//   Ready     out  initialisation done, Start is accepted
//   Valid     out  Top / Color / Column valid
//   Top       out  updated peak height
//   Color     out  integer part of the updated colour
//   Column    out  column index of this result
// ---------------------------------------------------------------------------
module bar_peak_shadow #(
    parameter int COLUMNS      = 800,
    parameter int ADDR_W       = 10,
    parameter int HEIGHT_W     = 7,
    parameter int COLOR_W      = 5,
    parameter int FP           = 2,
    parameter int COLOR_PRESET = 16,
    parameter int HOLD_FRAMES  = 4,
    parameter int FALL_STEP    = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Clear,
    input  logic                NewFrame,
    input  logic                Start,
    input  logic [HEIGHT_W-1:0] Bar,
    output logic                Ready,
    output logic                Valid,
    output logic [HEIGHT_W-1:0] Top,
    output logic [COLOR_W-1:0]  Color,
    output logic [ADDR_W-1:0]   Column
);

    // Stored colour keeps FP fractional bits so that the fade is slower than
    // one output step per frame.
    localparam int CW = COLOR_W + FP;
    // A zero-width hold field is not legal, so keep at least one bit. With
    // HOLD_FRAMES = 0 the field is always loaded with 0 and never counts.
    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    // The fall comparison is done wider than the height so that neither
    // Bar + step nor peak - step can wrap.
    localparam int SW = HEIGHT_W + 8;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(COLUMNS - 1);
    localparam logic [CW-1:0]     COLOR_LOAD = CW'(COLOR_PRESET << FP);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_FRAMES);
`ifdef BAR_PEAK_SHADOW_GRAVITY_EN
    localparam logic [2:0]        VEL_MAX    = 3'd7;
`endif

    // One RAM word per column.
    typedef struct packed {
`ifdef BAR_PEAK_SHADOW_GRAVITY_EN
        logic [2:0]          vel;
`endif
        logic [CW-1:0]       color;
        logic [HOLD_W-1:0]   hold;
        logic [HEIGHT_W-1:0] peak;
    } entry_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Control
    state_t              state_reg;
    logic [ADDR_W-1:0]   init_addr_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   ptr_next;
    logic                accept;

    // Column state RAM
    entry_t              mem [0:COLUMNS-1];
    entry_t              rd_data_reg;
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    entry_t              wdata;

    // Stage 1: address and sample registered, RAM data arriving
    logic                s1_valid_reg;
    logic [ADDR_W-1:0]   s1_addr_reg;
    logic [HEIGHT_W-1:0] s1_bar_reg;
    // A write that landed on the same edge as this stage's RAM read; the
    // read returned the old word, so the written word is kept here instead.
    logic                fwd_hit_reg;
    entry_t              fwd_data_reg;

    // Stage 2: result on the outputs, write-back data
    entry_t              wb_data_reg;

    // Update datapath
    entry_t              cur;
    entry_t              upd;
    logic [SW-1:0]       step;
    logic [SW-1:0]       limit;

    // -----------------------------------------------------------------------
    // Column addressing
    // -----------------------------------------------------------------------
    assign accept   = Start & Ready;
    // NewFrame redirects the current sample to column 0 as well as
    // restarting the pointer.
    assign rd_addr  = NewFrame ? '0 : ptr_reg;
    assign ptr_next = (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;

    // -----------------------------------------------------------------------
    // Control FSM: RAM initialisation sweep, then run. Ready is registered.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg     <= INIT;
            init_addr_reg <= '0;
            ptr_reg       <= '0;
            Ready         <= 1'b0;
        end else begin
            if (accept) begin
                ptr_reg <= ptr_next;
            end else if (NewFrame) begin
                ptr_reg <= '0;
            end

            case (state_reg)
                INIT: begin
                    if (Clear) begin
                        init_addr_reg <= '0;
                    end else if (init_addr_reg == LAST_ADDR) begin
                        init_addr_reg <= '0;
                        state_reg     <= RUN;
                        Ready         <= 1'b1;
                    end else begin
                        init_addr_reg <= init_addr_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (Clear) begin
                        state_reg     <= INIT;
                        init_addr_reg <= '0;
                        ptr_reg       <= '0;
                        Ready         <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= INIT;
                    Ready     <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // RAM write port. The initialisation sweep owns the port; write-backs of
    // results still in flight are dropped because the sweep zeroes every
    // column anyway, and a late write-back would undo the sweep.
    // -----------------------------------------------------------------------
    always_comb begin
        we    = 1'b0;
        waddr = Column;
        wdata = wb_data_reg;
        if (state_reg == INIT) begin
            we    = 1'b1;
            waddr = init_addr_reg;
            wdata = '0;
        end else begin
            we    = Valid;
        end
    end

    // Inferred RAM, read-before-write, registered read. No reset: the
    // contents are only ever defined by the initialisation sweep.
    always_ff @(posedge Clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_data_reg <= mem[rd_addr];
    end

    // -----------------------------------------------------------------------
    // Hazard resolution for the column being updated. Newest first:
    //   - the write going out this cycle (result one sample ahead),
    //   - the write that coincided with our read (two samples ahead),
    //   - otherwise the RAM word is current.
    // -----------------------------------------------------------------------
    always_comb begin
        if (we && (waddr == s1_addr_reg)) begin
            cur = wdata;
        end else if (fwd_hit_reg) begin
            cur = fwd_data_reg;
        end else begin
            cur = rd_data_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Peak / hold / colour update
    // -----------------------------------------------------------------------
    always_comb begin
        upd   = cur;
        step  = '0;
        limit = '0;
        if (s1_bar_reg > cur.peak) begin
            // New peak: capture, restart hold and colour.
            upd.peak  = s1_bar_reg;
            upd.hold  = HOLD_LOAD;
            upd.color = COLOR_LOAD;
`ifdef BAR_PEAK_SHADOW_GRAVITY_EN
            upd.vel   = '0;
`endif
        end else begin
            upd.color = (cur.color == '0) ? '0 : cur.color - 1'b1;
            if (cur.hold != '0) begin
                upd.hold = cur.hold - 1'b1;
            end else begin
`ifdef BAR_PEAK_SHADOW_GRAVITY_EN
                step    = SW'(FALL_STEP) + SW'(cur.vel);
                upd.vel = (cur.vel == VEL_MAX) ? VEL_MAX : cur.vel + 1'b1;
`else
                step    = SW'(FALL_STEP);
`endif
                // Falling peak never drops below the live bar.
                limit    = SW'(s1_bar_reg) + step;
                upd.peak = (SW'(cur.peak) > limit) ? HEIGHT_W'(SW'(cur.peak) - step)
                                                   : s1_bar_reg;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline: sample -> RAM data -> result/write-back
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_valid_reg <= 1'b0;
            s1_addr_reg  <= '0;
            s1_bar_reg   <= '0;
            fwd_hit_reg  <= 1'b0;
            fwd_data_reg <= '0;
            wb_data_reg  <= '0;
            Valid        <= 1'b0;
            Top          <= '0;
            Color        <= '0;
            Column       <= '0;
        end else begin
            s1_valid_reg <= accept;
            s1_addr_reg  <= rd_addr;
            s1_bar_reg   <= Bar;
            fwd_hit_reg  <= we && (waddr == rd_addr);
            fwd_data_reg <= wdata;

            Valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                Top         <= upd.peak;
                Color       <= upd.color[CW-1:FP];
                Column      <= s1_addr_reg;
                wb_data_reg <= upd;
            end
        end
    end

endmodule
